// File: rtl/lsu_mem_master_pkg.sv
// Shared encodings for the MEM-stage load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic {
        IDLE,
        RMW_WR
    } state_t;

endpackage

// File: rtl/lsu_mem_master_byte_lane_align.sv
// Little-endian lane steering: load extract/extend and sub-word store merge.
module byte_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [4:0]  w_sh;
    logic [31:0] w_lane;
    logic [31:0] w_mask;

    // Legal halves have i_off[0]=0, so one byte-granular shift serves both sizes.
    assign w_sh   = {i_off, 3'b000};
    assign w_lane = i_word >> w_sh;

    always_comb begin
        o_load = i_word;
        w_mask = '1;
        case (i_size)
            SZ_BYTE: begin
                o_load = {{24{~i_unsigned & w_lane[7]}}, w_lane[7:0]};
                w_mask = 32'h0000_00FF << w_sh;
            end
            SZ_HALF: begin
                o_load = {{16{~i_unsigned & w_lane[15]}}, w_lane[15:0]};
                w_mask = 32'h0000_FFFF << w_sh;
            end
            default: begin
                o_load = i_word;
                w_mask = '1;
            end
        endcase
    end

    assign o_merge = (i_word & ~w_mask) | ((i_wdata << w_sh) & w_mask);

endmodule

// File: rtl/lsu_mem_master.sv
// MEM-stage load/store initiator: word-wide memory access with sub-word
// read-modify-write stores, load extension and access error flagging.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              access_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_merge;
    logic [ADDR_W-1:0] r_addr;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_access_err;

    logic              w_err;
    logic              w_load_acc;
    logic              w_err_acc;
    logic              w_sub_store;
    logic [ADDR_W-1:0] w_word_addr;
    logic [DATA_W-1:0] w_load_val;
    logic [DATA_W-1:0] w_merge_val;

    assign w_word_addr = {req_addr[ADDR_W-1:2], 2'b00};
    assign w_err = (req_size == SZ_ILL)
                || ((req_size == SZ_HALF) && req_addr[0])
                || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

    byte_lane_align u_align (
        .i_word     (mem_rdata),
        .i_wdata    (req_wdata),
        .i_off      (req_addr[1:0]),
        .i_size     (req_size),
        .i_unsigned (req_unsigned),
        .o_load     (w_load_val),
        .o_merge    (w_merge_val)
    );

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = w_word_addr;
        mem_wdata   = req_wdata;
        w_load_acc  = 1'b0;
        w_err_acc   = 1'b0;
        w_sub_store = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_err) begin
                        req_ready = 1'b1;
                        w_err_acc = 1'b1;
                    end else if (!req_write) begin
                        mem_read   = 1'b1;
                        req_ready  = 1'b1;
                        w_load_acc = 1'b1;
                    end else if (req_size == SZ_WORD) begin
                        mem_write = 1'b1;
                        req_ready = 1'b1;
                    end else begin
                        mem_read    = 1'b1;
                        w_sub_store = 1'b1;
                        w_state_nxt = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                mem_write   = 1'b1;
                mem_addr    = r_addr;
                mem_wdata   = r_merge;
                req_ready   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        // Reset must suppress a pending RMW write before any clock edge arrives.
        if (!rst_n) begin
            req_ready = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_merge      <= '0;
            r_addr       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_access_err <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_resp_valid <= w_load_acc;
            r_access_err <= w_err_acc;
            if (w_load_acc) begin
                r_resp_rdata <= w_load_val;
            end
            if (w_sub_store) begin
                r_merge <= w_merge_val;
                r_addr  <= w_word_addr;
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign access_err = r_access_err;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized bench for lsu_mem_master against a transaction-level memory model.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        access_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [64];
    logic [31:0] mdl_mem [64];

    int n_checks = 0;
    int n_err = 0;
    bit chk_en = 0;

    logic        exp_ready, exp_rd, exp_wr, exp_rv, exp_err;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic        pend_rv = 0, pend_err = 0;
    logic [31:0] pend_rdata = '0;

    lsu_mem_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .access_err   (access_err),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr[7:2]];
    always @(posedge clk) if (mem_write) ram[mem_addr[7:2]] <= mem_wdata;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready",  32'(req_ready),  32'(exp_ready));
            check("mem_read",   32'(mem_read),   32'(exp_rd));
            check("mem_write",  32'(mem_write),  32'(exp_wr));
            check("resp_valid", 32'(resp_valid), 32'(exp_rv));
            check("access_err", 32'(access_err), 32'(exp_err));
            check("resp_rdata", resp_rdata, exp_rdata);
            if (exp_rd || exp_wr) check("mem_addr", mem_addr, exp_addr);
            if (exp_wr) check("mem_wdata", mem_wdata, exp_wdata);
        end
    end

    function automatic logic [31:0] mdl_load(input logic [31:0] w, input int unsigned a,
                                             input int unsigned sz, input bit u);
        int unsigned v;
        v = w >> (8 * (a % 4));
        if (sz == 0) begin
            v = v % 256;
            if (!u && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 1) begin
            v = v % 65536;
            if (!u && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] mdl_merge(input logic [31:0] w, input logic [31:0] d,
                                              input int unsigned a, input int unsigned sz);
        logic [7:0] b [4];
        int unsigned n;
        for (int k = 0; k < 4; k++) b[k] = 8'(w >> (8 * k));
        n = (sz == 0) ? 1 : 2;
        for (int unsigned k = 0; k < n; k++) b[(a % 4) + k] = 8'(d >> (8 * k));
        return {b[3], b[2], b[1], b[0]};
    endfunction

    function automatic bit mdl_err(input int unsigned sz, input int unsigned a);
        return (sz == 3) || (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
    endfunction

    task automatic begin_cycle();
        exp_rv    = pend_rv;
        exp_err   = pend_err;
        exp_rdata = pend_rdata;
        pend_rv   = 0;
        pend_err  = 0;
        exp_ready = 0;
        exp_rd    = 0;
        exp_wr    = 0;
        exp_addr  = '0;
        exp_wdata = '0;
    endtask

    task automatic do_reset(input int n);
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        pend_rv    = 0;
        pend_err   = 0;
        pend_rdata = '0;
        begin_cycle();
        repeat (n) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        begin_cycle();
        @(negedge clk);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        begin_cycle();
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        @(negedge clk);
    endtask

    task automatic do_req(input bit w, input int unsigned sz, input bit u,
                          input logic [7:0] a, input logic [31:0] d, input bit abort);
        int unsigned idx;
        logic [31:0] merged;
        idx = int'(a) / 4;
        @(posedge clk);
        #1;
        begin_cycle();
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = 2'(sz);
        req_unsigned = u;
        req_addr     = {24'h0, a};
        req_wdata    = d;
        exp_addr     = 32'(idx * 4);
        if (mdl_err(sz, int'(a))) begin
            exp_ready = 1;
            pend_err  = 1;
        end else if (!w) begin
            exp_ready  = 1;
            exp_rd     = 1;
            pend_rv    = 1;
            pend_rdata = mdl_load(mdl_mem[idx], int'(a), sz, u);
        end else if (sz == 2) begin
            exp_ready    = 1;
            exp_wr       = 1;
            exp_wdata    = d;
            mdl_mem[idx] = d;
        end else begin
            exp_rd = 1;
            merged = mdl_merge(mdl_mem[idx], d, int'(a), sz);
            @(negedge clk);
            @(posedge clk);
            #1;
            if (abort) begin
                do_reset(2);
                return;
            end
            begin_cycle();
            exp_ready    = 1;
            exp_wr       = 1;
            exp_addr     = 32'(idx * 4);
            exp_wdata    = merged;
            mdl_mem[idx] = merged;
        end
        @(negedge clk);
    endtask

    logic [7:0]  t_addr [4] = '{8'h23, 8'h23, 8'h22, 8'h20};
    int unsigned t_size [4] = '{0, 0, 1, 1};
    bit          t_uns  [4] = '{0, 1, 0, 1};
    logic [31:0] t_exp  [4] = '{32'hFFFF_FF88, 32'h0000_0088, 32'hFFFF_8899, 32'h0000_AABB};

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  ra;
        int unsigned rs, rsel;
        chk_en = 1;
        do_reset(3);

        for (int k = 0; k < 64; k++) do_req(1, 2, 0, 8'(k * 4), $urandom, 0);

        // Word store then load
        do_req(1, 2, 0, 8'h10, 32'hDEAD_BEEF, 0);
        check("sw_ready", 32'(req_ready), 32'd1);
        do_req(0, 2, 0, 8'h10, '0, 0);
        check("lw_read", 32'(mem_read), 32'd1);
        idle();
        check("lw_resp_valid", 32'(resp_valid), 32'd1);
        check("lw_resp_rdata", resp_rdata, 32'hDEAD_BEEF);

        // Byte store read-modify-write
        do_req(1, 2, 0, 8'h10, 32'h1122_3344, 0);
        do_req(1, 0, 0, 8'h11, 32'h0000_00AA, 0);
        check("sb_wdata", mem_wdata, 32'h1122_AA44);
        check("sb_ready", 32'(req_ready), 32'd1);
        idle();
        check("sb_ram", ram[4], 32'h1122_AA44);
        check("sb_model", mdl_mem[4], 32'h1122_AA44);

        // Load extension
        do_req(1, 2, 0, 8'h20, 32'h8899_AABB, 0);
        for (int k = 0; k < 4; k++) begin
            do_req(0, t_size[k], t_uns[k], t_addr[k], '0, 0);
            idle();
            check("ext_rdata", resp_rdata, t_exp[k]);
        end

        // Error requests
        do_req(0, 2, 0, 8'h22, '0, 0);
        do_req(1, 1, 0, 8'h21, 32'h1234, 0);
        do_req(0, 3, 0, 8'h24, '0, 0);
        idle();
        check("err_pulse", 32'(access_err), 32'd1);
        check("err_no_resp", 32'(resp_valid), 32'd0);
        idle();

        // Reset during RMW_WR
        do_req(1, 2, 0, 8'h30, 32'h1234_5678, 0);
        do_req(1, 1, 0, 8'h30, 32'h0000_BEEF, 1);
        check("rst_ram", ram[12], 32'h1234_5678);
        do_req(0, 2, 0, 8'h30, '0, 0);
        idle();
        check("rst_reload", resp_rdata, 32'h1234_5678);

        // Store then immediate load
        do_req(1, 2, 0, 8'h40, 32'h0, 0);
        do_req(1, 0, 0, 8'h41, 32'h0000_007F, 0);
        do_req(0, 2, 0, 8'h40, '0, 0);
        idle();
        check("fwd_rdata", resp_rdata, 32'h0000_7F00);

        for (int i = 0; i < 400; i++) begin
            rsel = $urandom_range(0, 9);
            rs = (rsel < 3) ? 0 : (rsel < 6) ? 1 : (rsel < 9) ? 2 : 3;
            ra = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) != 0) begin
                if (rs == 1) ra[0] = 1'b0;
                if (rs == 2) ra[1:0] = 2'b00;
            end
            do_req(1'($urandom), rs, 1'($urandom), ra, $urandom, 0);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        idle();

        for (int k = 0; k < 64; k++) check("final_ram", ram[k], mdl_mem[k]);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
